// File: rtl/mc1_sweep_capture.sv
// mc1_sweep_capture: steps every input combination of the MC1 function in
// ascending order, lets each one settle, samples F, and hands the assembled
// truth table plus its minterm count downstream over valid/ready.
module mc1_sweep_capture #(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [N_IN-1:0]         abcd_out,
    input  logic                    f_in,
    output logic                    busy,
    output logic [(1<<N_IN)-1:0]    table_out,
    output logic [N_IN:0]           minterm_count,
    output logic                    table_valid,
    input  logic                    table_ready
);

    localparam int unsigned TBL_W = 1 << N_IN;
    localparam int unsigned CNT_W = N_IN + 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  ABCD_LAST   = {N_IN{1'b1}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state_q,   state_nxt;
    logic [SET_W-1:0] settle_q,  settle_nxt;
    logic [N_IN-1:0]  abcd_nxt;
    logic [TBL_W-1:0] table_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             busy_nxt;
    logic             valid_nxt;

    // State and all outputs are registered; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            abcd_out      <= '0;
            table_out     <= '0;
            minterm_count <= '0;
            busy          <= 1'b0;
            table_valid   <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            settle_q      <= settle_nxt;
            abcd_out      <= abcd_nxt;
            table_out     <= table_nxt;
            minterm_count <= count_nxt;
            busy          <= busy_nxt;
            table_valid   <= valid_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_nxt  = state_q;
        settle_nxt = settle_q;
        abcd_nxt   = abcd_out;
        table_nxt  = table_out;
        count_nxt  = minterm_count;
        busy_nxt   = busy;
        valid_nxt  = table_valid;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    abcd_nxt   = '0;
                    table_nxt  = '0;
                    count_nxt  = '0;
                    settle_nxt = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                // f_in is deliberately ignored while MC1 settles.
                settle_nxt = settle_q + SET_W'(1);
                if (settle_q == SETTLE_LAST) begin
                    state_nxt = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                table_nxt[abcd_out] = f_in;
                count_nxt           = minterm_count + CNT_W'(f_in);
                if (abcd_out == ABCD_LAST) begin
                    valid_nxt = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    abcd_nxt   = abcd_out + N_IN'(1);
                    settle_nxt = '0;
                    state_nxt  = ST_SETTLE;
                end
            end

            ST_DONE: begin
                // Result held stable until the downstream handshake completes.
                if (table_valid && table_ready) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mc1_sweep_capture.sv
// tb_mc1_sweep_capture: directed checks of the sweep/capture block against a
// behavioural MC1 stand-in with selectable functions.
module tb_mc1_sweep_capture;

    localparam int unsigned SC      = 2;
    localparam int unsigned SWEEP_T = 16 * (SC + 1);

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  abcd_out;
    logic        f_in;
    logic        busy;
    logic [15:0] table_out;
    logic [4:0]  minterm_count;
    logic        table_valid;
    logic        table_ready;

    int n_checks;
    int n_fail;
    int mode;
    int lat;
    int terr;
    int stab;
    int guard;

    mc1_sweep_capture #(.N_IN(4), .SETTLE_CYCLES(SC)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abcd_out      (abcd_out),
        .f_in          (f_in),
        .busy          (busy),
        .table_out     (table_out),
        .minterm_count (minterm_count),
        .table_valid   (table_valid),
        .table_ready   (table_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MC1 stand-in: 0 = A&B, 1 = const 0, 2 = const 1, 3 = D.
    always_comb begin
        case (mode)
            0:       f_in = abcd_out[3] & abcd_out[2];
            1:       f_in = 1'b0;
            2:       f_in = 1'b1;
            default: f_in = abcd_out[0];
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge; counts clocks to table_valid and
    // checks abcd_out stays at value c/(SC+1) and busy stays high meanwhile.
    task automatic wait_valid(output int cycles, output int trace_err);
        int c;
        c = 0;
        trace_err = 0;
        while (!table_valid && c < 200) begin
            if (c < int'(SWEEP_T) && int'(abcd_out) != c / int'(SC + 1)) trace_err++;
            if (busy !== 1'b1) trace_err++;
            tick();
            c++;
        end
        cycles = c;
    endtask

    task automatic start_sweep(input bit hold);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    task automatic full_sweep(input int m, input string tag, input logic [15:0] exp_tbl,
                              input logic [4:0] exp_cnt);
        mode = m;
        start_sweep(1'b0);
        wait_valid(lat, terr);
        check_eq({tag, "_latency"}, 32'(lat), 32'(SWEEP_T));
        check_eq({tag, "_trace"}, 32'(terr), 32'd0);
        check_eq({tag, "_table"}, 32'(table_out), 32'(exp_tbl));
        check_eq({tag, "_count"}, 32'(minterm_count), 32'(exp_cnt));
        check_eq({tag, "_abcd15"}, 32'(abcd_out), 32'd15);
        table_ready = 1'b1;
        tick();
        table_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 32'(table_valid), 32'd0);
        check_eq({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check_eq({tag, "_table_kept"}, 32'(table_out), 32'(exp_tbl));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        mode        = 0;
        rst         = 1'b1;
        start       = 1'b0;
        table_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_abcd", 32'(abcd_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(table_valid), 32'd0);
        check_eq("rst_table", 32'(table_out), 32'd0);
        check_eq("rst_count", 32'(minterm_count), 32'd0);
        rst = 1'b0;

        // Ready asserted while idle must not do anything.
        table_ready = 1'b1;
        tick();
        table_ready = 1'b0;
        check_eq("idle_ready_valid", 32'(table_valid), 32'd0);
        check_eq("idle_ready_busy", 32'(busy), 32'd0);

        // A&B: minterms 12..15.
        full_sweep(0, "and", 16'hF000, 5'd4);
        full_sweep(1, "zero", 16'h0000, 5'd0);
        full_sweep(2, "one", 16'hFFFF, 5'd16);

        // F=D with downstream backpressure for 10 clocks.
        mode = 3;
        start_sweep(1'b0);
        wait_valid(lat, terr);
        check_eq("odd_latency", 32'(lat), 32'(SWEEP_T));
        stab = 0;
        for (int i = 0; i < 10; i++) begin
            if (table_valid !== 1'b1 || table_out !== 16'hAAAA || minterm_count !== 5'd8
                || abcd_out !== 4'd15) stab++;
            tick();
        end
        check_eq("odd_hold_stable", 32'(stab), 32'd0);
        check_eq("odd_still_valid", 32'(table_valid), 32'd1);
        table_ready = 1'b1;
        tick();
        table_ready = 1'b0;
        check_eq("odd_valid_drop", 32'(table_valid), 32'd0);
        check_eq("odd_table_kept", 32'(table_out), 32'hAAAA);
        check_eq("odd_count_kept", 32'(minterm_count), 32'd8);

        // start held high and ready held high through a whole sweep.
        mode = 0;
        table_ready = 1'b1;
        start_sweep(1'b1);
        wait_valid(lat, terr);
        check_eq("hold_latency", 32'(lat), 32'(SWEEP_T));
        check_eq("hold_no_restart", 32'(terr), 32'd0);
        check_eq("hold_table", 32'(table_out), 32'hF000);
        tick();
        check_eq("hold_hs_valid", 32'(table_valid), 32'd0);
        check_eq("hold_hs_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        table_ready = 1'b0;
        check_eq("hold_reaccept_busy", 32'(busy), 32'd1);
        check_eq("hold_reaccept_table", 32'(table_out), 32'd0);
        mode = 2;
        wait_valid(lat, terr);
        check_eq("hold_second_latency", 32'(lat), 32'(SWEEP_T));
        check_eq("hold_second_table", 32'(table_out), 32'hFFFF);
        table_ready = 1'b1;
        tick();
        table_ready = 1'b0;

        // Reset in the middle of settling on ABCD=7.
        mode = 2;
        start_sweep(1'b0);
        guard = 0;
        while (abcd_out != 4'd7 && guard < 200) begin
            tick();
            guard++;
        end
        check_eq("mid_reach7", 32'(abcd_out), 32'd7);
        tick();
        check_eq("mid_busy_before", 32'(busy), 32'd1);
        check_eq("mid_partial", 32'(table_out), 32'h007F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_abcd", 32'(abcd_out), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_valid", 32'(table_valid), 32'd0);
        check_eq("mid_rst_table", 32'(table_out), 32'd0);
        check_eq("mid_rst_count", 32'(minterm_count), 32'd0);
        full_sweep(3, "after_rst", 16'hAAAA, 5'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
